// File: rtl/aes_pkg.sv
// Shared AES-128 sequencing definitions: sizes, FSM encoding, mode constants
// and the expanded-key slicing helper.
package aes_pkg;

  localparam int unsigned NR      = 10;
  localparam int unsigned NK      = 4;
  localparam int unsigned BLOCK_W = NK * 32;
  localparam int unsigned KEYS_W  = (NR + 1) * BLOCK_W;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } state_t;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  // Round 0 (the cipher key) sits in the MSBs of the expanded-key bus.
  function automatic logic [BLOCK_W-1:0] round_key(input logic [KEYS_W-1:0] all_keys,
                                                   input int unsigned      r);
    return all_keys[(NR - r) * BLOCK_W +: BLOCK_W];
  endfunction

endpackage

// File: rtl/aes_round_key_select.sv
// Picks the round key for the current step and flags the final round; falls
// back to K0 with last deasserted whenever no round is in progress.
module aes_round_key_select #(
  parameter int unsigned NR     = aes_pkg::NR,
  parameter int unsigned KEYS_W = (NR + 1) * 128
) (
  input  logic [KEYS_W-1:0] all_keys,
  input  logic [3:0]        step,
  input  logic              mode,
  input  logic              active,
  output logic [127:0]      rnd_key_o,
  output logic              rnd_last_o
);
  import aes_pkg::*;

  localparam logic [3:0] LAST_STEP = 4'(NR);

  logic [3:0] idx;

  always_comb begin
    idx        = '0;
    rnd_last_o = 1'b0;
    if (active) begin
      idx        = (mode == MODE_DEC) ? (LAST_STEP - step) : step;
      rnd_last_o = (step == LAST_STEP);
    end
    rnd_key_o = all_keys[(NR - 32'(idx)) * 128 +: 128];
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 controller: initial AddRoundKey, NR steps through an
// external combinational round unit, result returned over valid/ready.
module aes_round_sequencer #(
  parameter int unsigned NR     = aes_pkg::NR,
  parameter int unsigned KEYS_W = (NR + 1) * 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [127:0]      in_data,
  input  logic [KEYS_W-1:0] all_keys,
  output logic [127:0]      rnd_state_o,
  output logic [127:0]      rnd_key_o,
  output logic              rnd_inv_o,
  output logic              rnd_last_o,
  input  logic [127:0]      rnd_result_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_data,
  output logic              out_mode,
  output logic              busy,
  output logic [15:0]       done_cnt
);
  import aes_pkg::*;

  localparam logic [3:0] LAST_STEP = 4'(NR);

  state_t       fsm, fsm_nxt;
  logic [3:0]   step;
  logic [127:0] st;
  logic         mode;
  logic [127:0] k_first, k_last;

  assign k_first = all_keys[KEYS_W-1 -: 128];
  assign k_last  = all_keys[127:0];

  assign rnd_state_o = st;
  assign out_data    = st;
  assign rnd_inv_o   = mode;
  assign out_mode    = mode;

  always_comb begin
    fsm_nxt   = fsm;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (fsm)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) fsm_nxt = ROUND;
      end
      ROUND: begin
        busy = 1'b1;
        if (step == LAST_STEP) fsm_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) fsm_nxt = IDLE;
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm      <= IDLE;
      step     <= '0;
      st       <= '0;
      mode     <= MODE_ENC;
      done_cnt <= '0;
    end else begin
      fsm <= fsm_nxt;
      unique case (fsm)
        IDLE: if (in_valid) begin
          st   <= in_data ^ ((in_mode == MODE_DEC) ? k_last : k_first);
          mode <= in_mode;
          step <= 4'd1;
        end
        ROUND: begin
          st <= rnd_result_i;
          // step saturates at NR so it only ever holds 1..NR once started
          if (step != LAST_STEP) step <= step + 4'd1;
        end
        DONE: if (out_ready) done_cnt <= done_cnt + 16'd1;
        default: ;
      endcase
    end
  end

  aes_round_key_select #(
    .NR    (NR),
    .KEYS_W(KEYS_W)
  ) u_key_sel (
    .all_keys  (all_keys),
    .step      (step),
    .mode      (mode),
    .active    (fsm == ROUND),
    .rnd_key_o (rnd_key_o),
    .rnd_last_o(rnd_last_o)
  );

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: reference AES round unit, key expansion and
// a {mode,data} scoreboard filled at accept and drained at the output.
module tb_aes_round_sequencer;
  localparam int NR = 10;
  localparam int KW = (NR + 1) * 128;
  localparam logic [127:0] KEY_F = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_F  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_F  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic          clk = 1'b0, rst = 1'b1;
  logic          in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b0;
  logic          in_ready, out_valid, out_mode, busy, rnd_inv_o, rnd_last_o;
  logic [127:0]  in_data = '0, rnd_result_i = '0;
  logic [127:0]  rnd_state_o, rnd_key_o, out_data;
  logic [KW-1:0] all_keys = '0;
  logic [15:0]   done_cnt;

  int checks = 0, failures = 0;
  logic [7:0]   sb [256];
  logic [7:0]   isb[256];
  logic [128:0] sb_q[$];
  logic [127:0] key_log[16];
  int           last_cnt;

  always #5 clk = ~clk;

  aes_round_sequencer #(.NR(NR), .KEYS_W(KW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .all_keys(all_keys), .rnd_state_o(rnd_state_o), .rnd_key_o(rnd_key_o),
    .rnd_inv_o(rnd_inv_o), .rnd_last_o(rnd_last_o), .rnd_result_i(rnd_result_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode),
    .busy(busy), .done_cnt(done_cnt)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] mixcol(input logic [31:0] c, input logic inv);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    if (!inv)
      return {gmul(2,a0)^gmul(3,a1)^a2^a3, a0^gmul(2,a1)^gmul(3,a2)^a3,
              a0^a1^gmul(2,a2)^gmul(3,a3), gmul(3,a0)^a1^a2^gmul(2,a3)};
    return {gmul(14,a0)^gmul(11,a1)^gmul(13,a2)^gmul(9,a3), gmul(9,a0)^gmul(14,a1)^gmul(11,a2)^gmul(13,a3),
            gmul(13,a0)^gmul(9,a1)^gmul(14,a2)^gmul(11,a3), gmul(11,a0)^gmul(13,a1)^gmul(9,a2)^gmul(14,a3)};
  endfunction

  // Forward: SubBytes, ShiftRows, MixColumns, AddKey.
  // Inverse: InvShiftRows, InvSubBytes, AddKey, InvMixColumns.
  function automatic logic [127:0] round_ref(input logic [127:0] s, input logic [127:0] k,
                                             input logic inv, input logic last);
    logic [7:0]   a[16], t[16];
    logic [127:0] u;
    for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!inv) t[r+4*c] = sb[a[r+4*((c+r)%4)]];
        else      t[r+4*((c+r)%4)] = isb[a[r+4*c]];
    for (int i = 0; i < 16; i++) u[127-8*i -: 8] = t[i];
    if (inv) u = u ^ k;
    if (!last)
      for (int c = 0; c < 4; c++) u[127-32*c -: 32] = mixcol(u[127-32*c -: 32], inv);
    if (!inv) u = u ^ k;
    return u;
  endfunction

  function automatic logic [KW-1:0] expand_key(input logic [127:0] key);
    logic [31:0]   w[44];
    logic [31:0]   t;
    logic [7:0]    rc = 8'h01;
    logic [KW-1:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) res[KW-1-32*i -: 32] = w[i];
    return res;
  endfunction

  function automatic logic [127:0] kslice(input int r);
    return all_keys[(NR - r) * 128 +: 128];
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] d, input logic m);
    logic [127:0] s = d ^ (m ? kslice(NR) : kslice(0));
    for (int r = 1; r <= NR; r++) s = round_ref(s, m ? kslice(NR - r) : kslice(r), m, r == NR);
    return s;
  endfunction

  // Reference round unit: recomputed mid-cycle from the registered DUT outputs.
  always @(negedge clk) rnd_result_i = round_ref(rnd_state_o, rnd_key_o, rnd_inv_o, rnd_last_o);

  task automatic accept(input logic m, input logic [127:0] d);
    int w = 0;
    @(negedge clk);
    in_valid = 1'b1; in_mode = m; in_data = d;
    while (in_ready !== 1'b1 && w < 30) begin @(negedge clk); w++; end
    checks++; if (w >= 30) begin failures++; $display("FAIL accept_wait in_ready=%b exp=1", in_ready); end
    sb_q.push_back({m, aes_ref(d, m)});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0; last_cnt = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      if (n < 16) key_log[n] = rnd_key_o;
      if (rnd_last_o === 1'b1) last_cnt++;
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic handshake();
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_mode = 1'b1; in_data = PT_F;
    all_keys = expand_key(KEY_F);
    repeat (3) @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (done_cnt !== 16'h0) begin failures++; $display("FAIL rst_done_cnt got=%h exp=0000", done_cnt); end
    checks++; if (rnd_state_o !== '0) begin failures++; $display("FAIL rst_state got=%h exp=0", rnd_state_o); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
    checks++; if ({out_mode, rnd_inv_o, rnd_last_o} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {out_mode, rnd_inv_o, rnd_last_o}); end
    checks++; if (rnd_key_o !== KEY_F) begin failures++; $display("FAIL rst_key got=%h exp=%h", rnd_key_o, KEY_F); end
    @(negedge clk) begin rst = 1'b0; in_mode = 1'b0; end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL first_accept_busy got=%b exp=1", busy); end
    checks++; if (rnd_state_o !== (PT_F ^ KEY_F)) begin failures++; $display("FAIL initial_ark got=%h exp=%h", rnd_state_o, PT_F ^ KEY_F); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
  endtask

  task automatic test_encrypt();
    int n; logic [128:0] exp; logic [15:0] c0;
    c0 = done_cnt;
    accept(1'b0, PT_F);
    wait_out(n);
    checks++; if (n != 10) begin failures++; $display("FAIL enc_latency got=%0d exp=11", n + 1); end
    checks++; if (last_cnt != 1) begin failures++; $display("FAIL enc_last_cycles got=%0d exp=1", last_cnt); end
    for (int i = 0; i < NR; i++) begin
      checks++; if (key_log[i] !== kslice(i + 1)) begin failures++; $display("FAIL enc_key%0d got=%h exp=%h", i + 1, key_log[i], kslice(i + 1)); end
    end
    exp = sb_q.pop_front();
    checks++; if ({out_mode, out_data} !== exp) begin failures++; $display("FAIL enc_scoreboard got=%h exp=%h", {out_mode, out_data}, exp); end
    checks++; if (out_data !== CT_F) begin failures++; $display("FAIL enc_fips got=%h exp=%h", out_data, CT_F); end
    handshake();
    checks++; if (done_cnt !== c0 + 16'd1) begin failures++; $display("FAIL enc_done_cnt got=%h exp=%h", done_cnt, c0 + 16'd1); end
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL enc_return_idle in_ready=%b out_valid=%b exp=1/0", in_ready, out_valid); end
  endtask

  task automatic test_decrypt();
    int n; logic [128:0] exp;
    accept(1'b1, CT_F);
    wait_out(n);
    checks++; if (n != 10) begin failures++; $display("FAIL dec_latency got=%0d exp=11", n + 1); end
    for (int i = 0; i < NR; i++) begin
      checks++; if (key_log[i] !== kslice(NR - 1 - i)) begin failures++; $display("FAIL dec_key%0d got=%h exp=%h", NR - 1 - i, key_log[i], kslice(NR - 1 - i)); end
    end
    exp = sb_q.pop_front();
    checks++; if ({out_mode, out_data} !== exp) begin failures++; $display("FAIL dec_scoreboard got=%h exp=%h", {out_mode, out_data}, exp); end
    checks++; if (out_data !== PT_F || out_mode !== 1'b1) begin failures++; $display("FAIL dec_fips got=%h/%b exp=%h/1", out_data, out_mode, PT_F); end
    handshake();
  endtask

  task automatic test_backpressure();
    int n; logic [128:0] exp; logic [15:0] c0;
    accept(1'b0, {$urandom, $urandom, $urandom, $urandom});
    wait_out(n);
    checks++; if (n >= 40) begin failures++; $display("FAIL bp_timeout out_valid=%b exp=1", out_valid); end
    exp = sb_q.pop_front();
    c0  = done_cnt;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({out_mode, out_data} !== exp || out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold%0d got=%h v=%b exp=%h", i, {out_mode, out_data}, out_valid, exp); end
      checks++; if (in_ready !== 1'b0 || done_cnt !== c0) begin failures++; $display("FAIL bp_idle%0d in_ready=%b cnt=%h exp=0/%h", i, in_ready, done_cnt, c0); end
      @(posedge clk); #1;
    end
    handshake();
    checks++; if (done_cnt !== c0 + 16'd1) begin failures++; $display("FAIL bp_done_cnt got=%h exp=%h", done_cnt, c0 + 16'd1); end
  endtask

  task automatic test_back_to_back();
    int c = 0, acc = 0, outs = 0;
    int t[2];
    logic [128:0] exp;
    logic [127:0] d1;
    d1 = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_mode = 1'b0; in_data = {$urandom, $urandom, $urandom, $urandom};
    while ((acc < 2 || outs < 2) && c < 100) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        exp = sb_q.pop_front();
        checks++; if ({out_mode, out_data} !== exp) begin failures++; $display("FAIL b2b_out%0d got=%h exp=%h", outs, {out_mode, out_data}, exp); end
        outs++;
      end
      if (in_ready === 1'b1 && in_valid === 1'b1) begin
        t[acc] = c; acc++;
        sb_q.push_back({in_mode, aes_ref(in_data, in_mode)});
      end
      @(posedge clk); #1;
      if (acc == 1) begin in_data = d1; in_mode = 1'b1; end
      if (acc == 2) in_valid = 1'b0;
      c++;
    end
    out_ready = 1'b0;
    checks++; if (acc != 2 || outs != 2) begin failures++; $display("FAIL b2b_count acc=%0d outs=%0d exp=2/2", acc, outs); end
    checks++; if (acc == 2 && t[1] - t[0] != 12) begin failures++; $display("FAIL b2b_period got=%0d exp=12", t[1] - t[0]); end
    checks++; if (done_cnt !== 16'd2) begin failures++; $display("FAIL b2b_done_cnt got=%h exp=0002", done_cnt); end
  endtask

  task automatic test_reset_mid();
    int n, seen = 0; logic [128:0] exp;
    accept(1'b1, {$urandom, $urandom, $urandom, $urandom});
    repeat (4) @(posedge clk); #1;
    checks++; if (busy !== 1'b1 || rnd_last_o !== 1'b0) begin failures++; $display("FAIL mid_step5 busy=%b last=%b exp=1/0", busy, rnd_last_o); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    checks++; if ({busy, out_valid, rnd_last_o, rnd_inv_o, out_mode} !== 5'b0) begin failures++; $display("FAIL mid_rst_flags got=%b exp=00000", {busy, out_valid, rnd_last_o, rnd_inv_o, out_mode}); end
    checks++; if (rnd_state_o !== '0 || out_data !== '0 || done_cnt !== 16'h0) begin failures++; $display("FAIL mid_rst_regs st=%h od=%h cnt=%h exp=0", rnd_state_o, out_data, done_cnt); end
    checks++; if (in_ready !== 1'b1 || rnd_key_o !== KEY_F) begin failures++; $display("FAIL mid_rst_idle in_ready=%b key=%h exp=1/%h", in_ready, rnd_key_o, KEY_F); end
    for (int i = 0; i < 15; i++) begin
      if (out_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL mid_no_output got=%0d exp=0", seen); end
    accept(1'b0, PT_F);
    wait_out(n);
    exp = sb_q.pop_front();
    checks++; if (out_data !== CT_F || exp[127:0] !== CT_F) begin failures++; $display("FAIL mid_fresh_enc got=%h exp=%h", out_data, CT_F); end
    handshake();
  endtask

  task automatic test_done_wrap();
    int n; logic [128:0] exp;
    @(negedge clk) force dut.done_cnt = 16'hFFFF;
    @(posedge clk); #1;
    release dut.done_cnt;
    accept(1'b0, {$urandom, $urandom, $urandom, $urandom});
    wait_out(n);
    exp = sb_q.pop_front();
    checks++; if ({out_mode, out_data} !== exp) begin failures++; $display("FAIL wrap_out got=%h exp=%h", {out_mode, out_data}, exp); end
    handshake();
    checks++; if (done_cnt !== 16'h0000) begin failures++; $display("FAIL wrap_done_cnt got=%h exp=0000", done_cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    build_sbox();
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_done_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
